icetap_capture_ctrl: RTL and testbench
======================================

Name: icetap_capture_ctrl

Overview:
Capture sequencer for the icetap logic analyzer. Consumes the command and status shift chains driven by the SPI front end and runs the arm/trigger/post-trigger state machine. Generates write addresses for the sample RAM, and read addresses for per-transaction readout over the data chain. Sits between the SPI front end, the trigger/store mask comparators and the sample RAM.

Parameters:
ADDR_BITS, 8, sample RAM address width; DEPTH = 2^ADDR_BITS
CMD_W, ADDR_BITS+2, command register width (derived, do not override)
STATUS_W, ADDR_BITS+4, status register width (derived, do not override)

Ports:
scan_clk  in  1  capture/scan clock; all logic on rising edge
scan_reset  in  1  synchronous reset, active-high
cmd_shift_ena  in  1  shift one command bit in
cmd_shift_data  in  1  command bit
cmd_shift_update  in  1  latch command shift register into command actions
status_shift_update  in  1  parallel-load status snapshot
status_shift_ena  in  1  shift status out by one bit
status_shift_data  out  1  status serial output (MSB of status shift reg)
data_shift_update  in  1  start of a data read transaction
sample_ena  in  1  sample strobe from probe front end
store  in  1  store-mask match for current sample
trigger  in  1  trigger-mask match for current sample
mem_wr  out  1  RAM write strobe
mem_waddr  out  ADDR_BITS  RAM write address
mem_rd  out  1  RAM read strobe (1-cycle pulse)
mem_raddr  out  ADDR_BITS  RAM read address
state  out  2  FSM state (debug)

Behaviour:
- Command shift reg: on cmd_shift_ena, cmd_sr <= {cmd_sr[CMD_W-2:0], cmd_shift_data}; MSB first. Fields: [ADDR_BITS-1:0] post_cnt, [ADDR_BITS] arm, [ADDR_BITS+1] abort.
- On cmd_shift_update, post_cnt is latched into post_cnt_r and arm/abort are evaluated in the same cycle. abort has priority over arm.
- FSM states: IDLE=0, ARMED=1, POST=2, DONE=3.
- abort: any state -> IDLE next cycle; wr_ptr, flags unchanged.
- arm, from IDLE or DONE: -> ARMED; wr_ptr<=0, wrapped<=0, triggered<=0, post_left<=post_cnt_r. arm in ARMED/POST is ignored.
- ARMED, sample_ena && trigger: sample written unconditionally (store ignored). trig_addr<=wr_ptr, triggered<=1. If post_left==0 -> DONE, else -> POST.
- ARMED, sample_ena && store && !trigger: write the sample, stay in ARMED.
- POST, sample_ena && store: write the sample, post_left decrements. The write that brings post_left to 0 moves the FSM to DONE. trigger is ignored in POST.
- Write: mem_wr = sample_ena && qualifying condition && state in {ARMED,POST}. Combinational, same cycle. mem_waddr = wr_ptr.
- wr_ptr increments after each write and wraps DEPTH-1 -> 0. A wrap sets wrapped<=1.
- post_cnt max is DEPTH-1, so the trigger sample is never overwritten.
- Entering DONE: rd_ptr <= wrapped(next) ? wr_ptr(next) : 0, i.e. the oldest sample.
- Readout: on data_shift_update in DONE, mem_rd pulses for 1 cycle, registered (1 cycle after update), with mem_raddr=rd_ptr; then rd_ptr increments modulo DEPTH.
- data_shift_update outside DONE: no mem_rd, rd_ptr unchanged. mem_raddr always reflects rd_ptr.
- Status snapshot: on status_shift_update, status_sr <= {state[1:0], triggered, wrapped, trig_addr}. On status_shift_ena, status_sr shifts left with 0 in. status_shift_data = status_sr[STATUS_W-1]. update wins over ena if both are asserted.
- Simultaneous cmd_shift_update arm and sample_ena in IDLE: no write that cycle; capture begins the next cycle.
- Reset values: state=IDLE, all pointers/counters/flags/shift regs 0, mem_wr=0, mem_rd=0, status_shift_data=0.
- Reset mid-capture returns to IDLE without any write in the reset cycle.

Test Plan:
- Reset, then status read (update + 12 ena): serial stream all zeros; state=0.
- ADDR_BITS=8. Shift cmd arm=1, post_cnt=3. Drive sample_ena every cycle, store=1, trigger at the 5th sample -> writes at addr 0..7, trig_addr=4, DONE after addr 7. Status shows 3,1,0,0x04.
- Arm with post_cnt=0, store=1, 300 pre-trigger samples then trigger -> wrapped=1, trig_addr=300 mod 256=44. First data_shift_update gives mem_raddr=45 (oldest); the second gives 46.
- Arm, store=0 with no trigger for 50 samples, then a trigger sample -> exactly one mem_wr at addr 0; the trigger sample is stored despite store=0.
- Shift cmd with arm=1, abort=1 while in POST -> IDLE next cycle, no further mem_wr. A subsequent arm clears wrapped/triggered.
- Assert scan_reset during POST with sample_ena high -> mem_wr=0 that cycle. state=IDLE, mem_waddr=0 the next cycle.

Source files
------------

// File: rtl/icetap_capture_ctrl.sv
// icetap capture sequencer: command/status shift chains, arm/trigger/post-trigger
// FSM, sample RAM write addressing and per-transaction readout addressing.
module icetap_capture_ctrl #(
  parameter  int ADDR_BITS = 8,
  localparam int CMD_W     = ADDR_BITS + 2,
  localparam int STATUS_W  = ADDR_BITS + 4
) (
  input  logic                 scan_clk,
  input  logic                 scan_reset,
  input  logic                 cmd_shift_ena,
  input  logic                 cmd_shift_data,
  input  logic                 cmd_shift_update,
  input  logic                 status_shift_update,
  input  logic                 status_shift_ena,
  output logic                 status_shift_data,
  input  logic                 data_shift_update,
  input  logic                 sample_ena,
  input  logic                 store,
  input  logic                 trigger,
  output logic                 mem_wr,
  output logic [ADDR_BITS-1:0] mem_waddr,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_raddr,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [CMD_W-1:0]     cmd_sr;
  logic [STATUS_W-1:0]  status_sr;
  logic [ADDR_BITS-1:0] post_cnt_r;
  logic [ADDR_BITS-1:0] post_left;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS-1:0] trig_addr;
  logic                 wrapped;
  logic                 triggered;

  // command decode; abort overrides arm when both bits are set
  logic                 abort_cmd, arm_cmd;
  logic [ADDR_BITS-1:0] cmd_post;

  assign cmd_post  = cmd_sr[ADDR_BITS-1:0];
  assign abort_cmd = cmd_shift_update && cmd_sr[ADDR_BITS+1];
  assign arm_cmd   = cmd_shift_update && cmd_sr[ADDR_BITS] && !abort_cmd;

  logic                 wr_en, trig_hit, post_dec, arm_go;
  logic [ADDR_BITS-1:0] wr_ptr_n;
  logic                 wrapped_n;

  always_comb begin
    state_n  = state_q;
    wr_en    = 1'b0;
    trig_hit = 1'b0;
    post_dec = 1'b0;
    arm_go   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm_cmd) begin
          state_n = S_ARMED;
          arm_go  = 1'b1;
        end
      end
      S_ARMED: begin
        // the trigger sample is always kept, regardless of the store mask
        if (sample_ena && trigger) begin
          wr_en    = 1'b1;
          trig_hit = 1'b1;
          state_n  = (post_left == '0) ? S_DONE : S_POST;
        end else if (sample_ena && store) begin
          wr_en = 1'b1;
        end
      end
      S_POST: begin
        if (sample_ena && store) begin
          wr_en    = 1'b1;
          post_dec = 1'b1;
          if (post_left == ADDR_BITS'(1)) state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (arm_cmd) begin
          state_n = S_ARMED;
          arm_go  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // abort freezes pointers and flags, so the sample in that cycle is dropped
    if (abort_cmd || scan_reset) begin
      state_n  = S_IDLE;
      wr_en    = 1'b0;
      trig_hit = 1'b0;
      post_dec = 1'b0;
      arm_go   = 1'b0;
    end
  end

  assign wr_ptr_n  = wr_ptr + 1'b1;
  assign wrapped_n = wrapped || (wr_ptr == '1);

  always_ff @(posedge scan_clk) begin
    if (scan_reset) begin
      state_q    <= S_IDLE;
      cmd_sr     <= '0;
      status_sr  <= '0;
      post_cnt_r <= '0;
      post_left  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trig_addr  <= '0;
      wrapped    <= 1'b0;
      triggered  <= 1'b0;
      mem_rd     <= 1'b0;
    end else begin
      state_q <= state_n;

      if (cmd_shift_ena)    cmd_sr     <= {cmd_sr[CMD_W-2:0], cmd_shift_data};
      if (cmd_shift_update) post_cnt_r <= cmd_post;

      if (arm_go) begin
        // post_cnt is latched in this same cycle, so take it straight from the chain
        wr_ptr    <= '0;
        wrapped   <= 1'b0;
        triggered <= 1'b0;
        post_left <= cmd_post;
      end else if (wr_en) begin
        wr_ptr  <= wr_ptr_n;
        wrapped <= wrapped_n;
        if (trig_hit) begin
          trig_addr <= wr_ptr;
          triggered <= 1'b1;
        end
        if (post_dec) post_left <= post_left - 1'b1;
      end

      mem_rd <= data_shift_update && (state_q == S_DONE);
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      // entering DONE always coincides with a write; point at the oldest sample
      if (state_n == S_DONE && state_q != S_DONE)
        rd_ptr <= wrapped_n ? wr_ptr_n : '0;

      if (status_shift_update)
        status_sr <= {state_q, triggered, wrapped, trig_addr};
      else if (status_shift_ena)
        status_sr <= {status_sr[STATUS_W-2:0], 1'b0};
    end
  end

  assign mem_wr            = wr_en;
  assign mem_waddr         = wr_ptr;
  assign mem_raddr         = rd_ptr;
  assign state             = state_q;
  assign status_shift_data = status_sr[STATUS_W-1];

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Directed bench for icetap_capture_ctrl; RAM write/read addresses are
// checked against a scoreboard of expected accesses.
module tb_icetap_capture_ctrl;
  localparam int AB = 8;
  localparam int SW = AB + 4;
  localparam int CW = AB + 2;

  logic scan_clk = 1'b0;
  logic scan_reset, cmd_shift_ena, cmd_shift_data, cmd_shift_update;
  logic status_shift_update, status_shift_ena, status_shift_data;
  logic data_shift_update, sample_ena, store, trigger;
  logic mem_wr, mem_rd;
  logic [AB-1:0] mem_waddr, mem_raddr;
  logic [1:0] state;

  int passed = 0;
  int total  = 0;
  int wq[$];
  int rq[$];

  icetap_capture_ctrl #(.ADDR_BITS(AB)) dut (
    .scan_clk(scan_clk), .scan_reset(scan_reset),
    .cmd_shift_ena(cmd_shift_ena), .cmd_shift_data(cmd_shift_data),
    .cmd_shift_update(cmd_shift_update),
    .status_shift_update(status_shift_update), .status_shift_ena(status_shift_ena),
    .status_shift_data(status_shift_data), .data_shift_update(data_shift_update),
    .sample_ena(sample_ena), .store(store), .trigger(trigger),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
    .state(state)
  );

  always #5 scan_clk = ~scan_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  // write / read scoreboards, sampled mid-cycle
  always @(negedge scan_clk) begin
    if (mem_wr === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_wr", 32'(mem_waddr), 32'hFFFF_FFFF);
      else chk("wr_addr", 32'(mem_waddr), 32'(wq.pop_front()));
    end
    if (mem_rd === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_rd", 32'(mem_raddr), 32'hFFFF_FFFF);
      else chk("rd_addr", 32'(mem_raddr), 32'(rq.pop_front()));
    end
  end

  task automatic send_cmd(input logic abort, input logic arm, input logic [AB-1:0] post);
    logic [CW-1:0] v;
    v = {abort, arm, post};
    for (int i = CW - 1; i >= 0; i--) begin
      cmd_shift_ena  = 1'b1;
      cmd_shift_data = v[i];
      tick();
    end
    cmd_shift_ena    = 1'b0;
    cmd_shift_data   = 1'b0;
    cmd_shift_update = 1'b1;
    tick();
    cmd_shift_update = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [SW-1:0] exp);
    logic [SW-1:0] got;
    status_shift_update = 1'b1;
    tick();
    status_shift_update = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      got[i] = status_shift_data;
      status_shift_ena = 1'b1;
      tick();
    end
    status_shift_ena = 1'b0;
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic sample(input logic st, input logic tr, input bit expect_wr, input int addr);
    sample_ena = 1'b1;
    store      = st;
    trigger    = tr;
    if (expect_wr) wq.push_back(addr);
    tick();
    sample_ena = 1'b0;
    store      = 1'b0;
    trigger    = 1'b0;
  endtask

  task automatic readout(input int addr);
    rq.push_back(addr);
    data_shift_update = 1'b1;
    tick();
    data_shift_update = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    scan_reset = 1'b1;
    cmd_shift_ena = 0; cmd_shift_data = 0; cmd_shift_update = 0;
    status_shift_update = 0; status_shift_ena = 0; data_shift_update = 0;
    sample_ena = 0; store = 0; trigger = 0;
    tick(); tick();
    scan_reset = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_sdata", 32'(status_shift_data), 0);
    chk("rst_waddr", 32'(mem_waddr), 0);
    read_status("rst_status", 12'h000);

    // basic capture: trigger on the 5th sample, 3 post samples
    send_cmd(1'b0, 1'b1, 8'd3);
    chk("armed", 32'(state), 1);
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, i == 4, 1'b1, i);
      if (i == 4) chk("post_state", 32'(state), 2);
    end
    chk("done_state", 32'(state), 3);
    sample(1'b1, 1'b1, 1'b0, 0);
    read_status("status_basic", 12'hE04);
    chk("raddr_basic", 32'(mem_raddr), 0);
    readout(0);
    chk("raddr_basic_inc", 32'(mem_raddr), 1);

    // wrap: 300 pre-trigger samples, post_cnt=0
    send_cmd(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 300; i++) sample(1'b1, 1'b0, 1'b1, i % 256);
    sample(1'b1, 1'b1, 1'b1, 44);
    chk("wrap_done", 32'(state), 3);
    read_status("status_wrap", 12'hF2C);
    chk("raddr_oldest", 32'(mem_raddr), 45);
    readout(45);
    readout(46);
    chk("raddr_after2", 32'(mem_raddr), 47);

    // store=0: only the trigger sample lands
    send_cmd(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 50; i++) sample(1'b0, 1'b0, 1'b0, 0);
    sample(1'b0, 1'b1, 1'b1, 0);
    chk("nostore_done", 32'(state), 3);
    read_status("status_nostore", 12'hE00);

    // abort in POST (arm bit also set: abort wins)
    send_cmd(1'b0, 1'b1, 8'd5);
    sample(1'b1, 1'b1, 1'b1, 0);
    chk("abort_pre_post", 32'(state), 2);
    sample(1'b1, 1'b0, 1'b1, 1);
    sample(1'b1, 1'b0, 1'b1, 2);
    send_cmd(1'b1, 1'b1, 8'd0);
    chk("abort_idle", 32'(state), 0);
    for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, 1'b0, 0);
    read_status("status_abort", 12'h200);
    send_cmd(1'b0, 1'b1, 8'd2);
    read_status("status_rearm", 12'h400);

    // reset during POST with a qualifying sample
    sample(1'b1, 1'b1, 1'b1, 0);
    sample(1'b1, 1'b0, 1'b1, 1);
    chk("rst_pre_post", 32'(state), 2);
    sample_ena = 1'b1; store = 1'b1; scan_reset = 1'b1;
    #2;
    chk("rst_cycle_wr", 32'(mem_wr), 0);
    tick();
    scan_reset = 1'b0; sample_ena = 1'b0; store = 1'b0;
    chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_waddr", 32'(mem_waddr), 0);

    // arm update concurrent with a sample in IDLE: capture starts next cycle
    sample_ena = 1'b1; store = 1'b1;
    send_cmd(1'b0, 1'b1, 8'd0);
    sample(1'b1, 1'b0, 1'b1, 0);
    sample(1'b1, 1'b1, 1'b1, 1);
    chk("arm_same_cycle_done", 32'(state), 3);

    tick(); tick();
    chk("wq_drained", 32'(wq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
